// File: rtl/ppt_spi_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : ppt_spi_regs_if
// Description : SPI slave pin bundle for the pulse-generator register block.
//               The slave modport is used by ppt_spi_regs; the master modport
//               is for whatever drives the bus (an SPI master or a bench).
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Signals:
//   spi_sck   SPI clock, mode 0, asynchronous to the system clock
//   spi_cs_n  chip select, active-low, frame delimiter
//   spi_mosi  serial data towards the slave, MSB first
//   spi_miso  serial data from the slave, MSB first
// ============================================================================
interface ppt_spi_regs_if;
  logic spi_sck;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport slave (
    input  spi_sck,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );

  modport master (
    output spi_sck,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );
endinterface
`default_nettype wire

// File: rtl/ppt_spi_regs.sv
`default_nettype none
// ============================================================================
// Module      : ppt_spi_regs
// Description : SPI mode-0 slave exposing the control registers of a pulse
//               generator. 24-bit frames: W bit, 7-bit address, 16-bit data.
//               All SPI pins are resynchronised into clk; writes commit on
//               chip-select release only when exactly 24 sck rises were seen.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Optional feature macro: PPT_SPI_PULSE_COUNT_EN
//   defined   : COUNT (0x03) counts synchronised pulse_in rises while run=1
//   undefined : no counter, 0x03 reads 16'h0000
// ----------------------------------------------------------------------------
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   spi           SPI pins (ppt_spi_regs_if.slave)
//   pulse_in      generator output fed back for STATUS / COUNT
//   pulse_period  PERIOD register (0x00)
//   pulse_width   WIDTH register (0x01)
//   run           CTRL[0] (0x02), generator enable
// Register map:
//   0x00 PERIOD RW, 0x01 WIDTH RW, 0x02 CTRL RW (bit0 run),
//   0x03 COUNT RO, 0x04 STATUS RO (bit0 run, bit1 pulse_in), others read 0
// ============================================================================
module ppt_spi_regs #(
  parameter logic [15:0] PERIOD_RST = 16'd128,
  parameter logic [15:0] WIDTH_RST  = 16'd1
) (
  input  wire           clk,
  input  wire           rst_n,
  ppt_spi_regs_if.slave spi,
  input  wire           pulse_in,
  output logic [15:0]   pulse_period,
  output logic [15:0]   pulse_width,
  output logic          run
);

  localparam logic [6:0] c_ADDR_PERIOD = 7'h00;
  localparam logic [6:0] c_ADDR_WIDTH  = 7'h01;
  localparam logic [6:0] c_ADDR_CTRL   = 7'h02;
  localparam logic [6:0] c_ADDR_COUNT  = 7'h03;
  localparam logic [6:0] c_ADDR_STATUS = 7'h04;

  localparam logic [4:0] c_LAST_HDR_BIT = 5'd7;   // count before the 8th rise
  localparam logic [4:0] c_FIRST_DATA   = 5'd8;
  localparam logic [4:0] c_LAST_DATA    = 5'd23;
  localparam logic [4:0] c_FRAME_BITS   = 5'd24;
  localparam logic [4:0] c_CNT_SAT      = 5'd31;

  // --------------------------------------------------------------------------
  // Synchronisers. Index [1] is the synchronised value, [2] its previous
  // value for edge detection.
  // --------------------------------------------------------------------------
  logic [2:0] r_sck_sync;
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync;
  logic [1:0] r_pulse_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync   <= 3'b000;
      r_cs_sync    <= 3'b111;
      r_mosi_sync  <= 2'b00;
      r_pulse_sync <= 2'b00;
    end else begin
      r_sck_sync   <= {r_sck_sync[1:0], spi.spi_sck};
      r_cs_sync    <= {r_cs_sync[1:0], spi.spi_cs_n};
      r_mosi_sync  <= {r_mosi_sync[0], spi.spi_mosi};
      r_pulse_sync <= {r_pulse_sync[0], pulse_in};
    end
  end

  // After reset the cs_n chain holds its idle value for two cycles. If the pin
  // is still low (reset hit mid-frame) that would look like a fresh cs_n fall,
  // so a fall is only accepted once cs_n has genuinely been seen high.
  logic [1:0] r_warm;
  logic       r_cs_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm   <= 2'b00;
      r_cs_arm <= 1'b0;
    end else begin
      r_warm <= {r_warm[0], 1'b1};
      if (r_warm[1] && r_cs_sync[1]) begin
        r_cs_arm <= 1'b1;
      end
    end
  end

  logic w_cs_fall;
  logic w_cs_rise;
  logic w_sck_rise;
  logic w_sck_fall;
  logic r_in_frame;

  assign w_cs_fall  = r_cs_arm & r_cs_sync[2] & ~r_cs_sync[1];
  assign w_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
  // sck edges count only inside a frame that began with a seen cs_n fall
  assign w_sck_rise = r_in_frame & ~r_cs_sync[1] &  r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = r_in_frame & ~r_cs_sync[1] & ~r_sck_sync[1] &  r_sck_sync[2];

  // --------------------------------------------------------------------------
  // Frame shifter
  // --------------------------------------------------------------------------
  logic [4:0]  r_bit_cnt;
  logic [23:0] r_shift;
  logic [15:0] r_tx;
  logic        r_miso;
  logic [23:0] w_shift_nxt;
  logic [6:0]  w_rd_addr;
  logic [15:0] w_rd_data;

  assign w_shift_nxt = {r_shift[22:0], r_mosi_sync[1]};
  // Address as it will stand once the 8th bit is shifted in
  assign w_rd_addr   = w_shift_nxt[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_frame <= 1'b0;
      r_bit_cnt  <= 5'd0;
      r_shift    <= 24'd0;
      r_tx       <= 16'd0;
      r_miso     <= 1'b0;
    end else if (w_cs_rise) begin
      r_in_frame <= 1'b0;
      r_miso     <= 1'b0;
    end else if (w_cs_fall) begin
      r_in_frame <= 1'b1;
      r_bit_cnt  <= 5'd0;
      r_shift    <= 24'd0;
      r_tx       <= 16'd0;
      r_miso     <= 1'b0;
    end else if (w_sck_rise) begin
      r_shift <= w_shift_nxt;
      // saturating so over-long frames never alias back to 24
      if (r_bit_cnt != c_CNT_SAT) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (r_bit_cnt == c_LAST_HDR_BIT) begin
        // write frames load zero so miso stays low for the whole frame
        r_tx <= w_shift_nxt[7] ? 16'd0 : w_rd_data;
      end
    end else if (w_sck_fall) begin
      if ((r_bit_cnt >= c_FIRST_DATA) && (r_bit_cnt <= c_LAST_DATA)) begin
        r_miso <= r_tx[15];
        r_tx   <= {r_tx[14:0], 1'b0};
      end else begin
        r_miso <= 1'b0;
      end
    end
  end

  assign spi.spi_miso = r_miso;

  // --------------------------------------------------------------------------
  // Registers. The frame is still intact in r_shift at cs_n rise, so W,
  // address and data are taken straight from it.
  // --------------------------------------------------------------------------
  logic        w_commit;
  logic [6:0]  w_wr_addr;
  logic [15:0] w_wr_data;
  logic [15:0] r_period;
  logic [15:0] r_width;
  logic        r_run;
  logic [15:0] w_count;

  assign w_wr_addr = r_shift[22:16];
  assign w_wr_data = r_shift[15:0];
  assign w_commit  = w_cs_rise & r_in_frame & (r_bit_cnt == c_FRAME_BITS) & r_shift[23];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= PERIOD_RST;
      r_width  <= WIDTH_RST;
      r_run    <= 1'b0;
    end else if (w_commit) begin
      case (w_wr_addr)
        c_ADDR_PERIOD: r_period <= w_wr_data;
        c_ADDR_WIDTH:  r_width  <= w_wr_data;
        c_ADDR_CTRL:   r_run    <= w_wr_data[0];
        default: ;
      endcase
    end
  end

`ifdef PPT_SPI_PULSE_COUNT_EN
  logic        r_pulse_d;
  logic [15:0] r_count;
  logic        w_pulse_rise;

  assign w_pulse_rise = r_pulse_sync[1] & ~r_pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse_d <= 1'b0;
      r_count   <= 16'd0;
    end else begin
      r_pulse_d <= r_pulse_sync[1];
      if (w_commit && (w_wr_addr == c_ADDR_CTRL)) begin
        r_count <= 16'd0;
      end else if (r_run && w_pulse_rise) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign w_count = r_count;
`else
  assign w_count = 16'd0;
`endif

  always_comb begin
    w_rd_data = 16'd0;
    case (w_rd_addr)
      c_ADDR_PERIOD: w_rd_data = r_period;
      c_ADDR_WIDTH:  w_rd_data = r_width;
      c_ADDR_CTRL:   w_rd_data = {15'd0, r_run};
      c_ADDR_COUNT:  w_rd_data = w_count;
      c_ADDR_STATUS: w_rd_data = {14'd0, r_pulse_sync[1], r_run};
      default:       w_rd_data = 16'd0;
    endcase
  end

  assign pulse_period = r_period;
  assign pulse_width  = r_width;
  assign run          = r_run;

endmodule
`default_nettype wire

// File: tb/tb_ppt_spi_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppt_spi_regs
// Description : Directed self-checking bench for ppt_spi_regs. Drives SPI
//               frames bit by bit and compares outputs against hand-computed
//               values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ppt_spi_regs;

  localparam int HALF = 8;   // sck half period in clk cycles

  logic        clk;
  logic        rst_n;
  logic        pulse_in;
  logic [15:0] pulse_period;
  logic [15:0] pulse_width;
  logic        run;
  logic [15:0] rd;

  int n_pass;
  int n_total;

  ppt_spi_regs_if u_if ();

  ppt_spi_regs u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (u_if.slave),
    .pulse_in     (pulse_in),
    .pulse_period (pulse_period),
    .pulse_width  (pulse_width),
    .run          (run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, observed=running required=done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One SPI frame; nbits sck pulses, optional reset pulse before bit rst_at.
  task automatic spi_xfer(input logic w, input logic [6:0] addr, input logic [15:0] data,
                          input int nbits, input int rst_at, output logic [15:0] rdata);
    logic [23:0] frame;
    frame = {w, addr, data};
    rdata = 16'd0;
    @(negedge clk);
    u_if.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      u_if.spi_mosi = (i < 24) ? frame[23 - i] : 1'b0;
      repeat (HALF) @(negedge clk);
      u_if.spi_sck = 1'b1;
      if (i >= 8 && i < 24) rdata[23 - i] = u_if.spi_miso;
      repeat (HALF) @(negedge clk);
      u_if.spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    u_if.spi_cs_n = 1'b1;
    // committed values must be visible within 4 clk of the cs_n rise
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    pulse_in      = 1'b0;
    u_if.spi_cs_n = 1'b1;
    u_if.spi_sck  = 1'b0;
    u_if.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // reset state
    check("rst_period", pulse_period, 16'h0080);
    check("rst_width",  pulse_width,  16'h0001);
    check("rst_run",    {15'd0, run}, 16'h0000);
    check("rst_miso",   {15'd0, u_if.spi_miso}, 16'h0000);

    // reset values read back
    spi_xfer(1'b0, 7'h00, 16'h0000, 24, -1, rd); check("rd_period_rst", rd, 16'h0080);
    spi_xfer(1'b0, 7'h01, 16'h0000, 24, -1, rd); check("rd_width_rst",  rd, 16'h0001);
    spi_xfer(1'b0, 7'h02, 16'h0000, 24, -1, rd); check("rd_ctrl_rst",   rd, 16'h0000);

    // writes
    spi_xfer(1'b1, 7'h00, 16'h03E8, 24, -1, rd);
    check("wr_period", pulse_period, 16'd1000);
    check("miso_wr_frame", rd, 16'h0000);
    spi_xfer(1'b1, 7'h01, 16'h0010, 24, -1, rd);
    check("wr_width", pulse_width, 16'd16);
    spi_xfer(1'b1, 7'h02, 16'h0001, 24, -1, rd);
    check("wr_run", {15'd0, run}, 16'h0001);

    // short frame discarded
    spi_xfer(1'b1, 7'h01, 16'hABCD, 20, -1, rd);
    check("short_width", pulse_width, 16'h0010);
    spi_xfer(1'b0, 7'h01, 16'h0000, 24, -1, rd);
    check("short_rd_width", rd, 16'h0010);

    // long frame discarded
    spi_xfer(1'b1, 7'h01, 16'h5555, 25, -1, rd);
    check("long_width", pulse_width, 16'h0010);

`ifdef PPT_SPI_PULSE_COUNT_EN
    for (int p = 0; p < 5; p++) begin
      pulse_in = 1'b1;
      repeat (4) @(negedge clk);
      pulse_in = 1'b0;
      repeat (4) @(negedge clk);
    end
    spi_xfer(1'b0, 7'h03, 16'h0000, 24, -1, rd); check("count_5", rd, 16'h0005);
    spi_xfer(1'b1, 7'h02, 16'h0001, 24, -1, rd);
    spi_xfer(1'b0, 7'h03, 16'h0000, 24, -1, rd); check("count_clr", rd, 16'h0000);
`else
    spi_xfer(1'b0, 7'h03, 16'h0000, 24, -1, rd); check("count_absent", rd, 16'h0000);
`endif

    // status with pulse_in high and run=1
    pulse_in = 1'b1;
    spi_xfer(1'b0, 7'h04, 16'h0000, 24, -1, rd); check("status", rd, 16'h0003);
    pulse_in = 1'b0;

    // unmapped address
    spi_xfer(1'b1, 7'h05, 16'hFFFF, 24, -1, rd);
    spi_xfer(1'b0, 7'h05, 16'h0000, 24, -1, rd); check("rd_unmapped", rd, 16'h0000);
    check("unm_period", pulse_period, 16'h03E8);
    check("unm_width",  pulse_width,  16'h0010);
    check("unm_run",    {15'd0, run}, 16'h0001);

    // run off
    spi_xfer(1'b1, 7'h02, 16'h0000, 24, -1, rd);
    check("run_off", {15'd0, run}, 16'h0000);

    // reset mid-frame at bit 12: frame aborted, reset values stay
    spi_xfer(1'b1, 7'h00, 16'h1234, 24, 12, rd);
    check("rstmid_period", pulse_period, 16'h0080);
    check("rstmid_width",  pulse_width,  16'h0001);
    spi_xfer(1'b0, 7'h00, 16'h0000, 24, -1, rd); check("rstmid_rd", rd, 16'h0080);

    check("idle_miso", {15'd0, u_if.spi_miso}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ppt_spi_regs.md
PPT_SPI_REGS -- requirements
Module: ppt_spi_regs

Interface
REQ-001 Parameter PERIOD_RST, default 16'd128, reset value of the PERIOD register.
REQ-002 Parameter WIDTH_RST, default 16'd1, reset value of the WIDTH register.
REQ-003 clk  input  1  system clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 spi_sck  input  1  SPI clock, mode 0, asynchronous to clk, frequency ≤ clk/8.
REQ-006 spi_cs_n  input  1  SPI chip select, active-low, frame delimiter.
REQ-007 spi_mosi  input  1  SPI serial data in, MSB first.
REQ-008 spi_miso  output  1  SPI serial data out, MSB first.
REQ-009 pulse_in  input  1  pulse generator output, fed back for status and count.
REQ-010 pulse_period  output  16  period setting to the pulse generator (PERIOD register).
REQ-011 pulse_width  output  16  width setting to the pulse generator (WIDTH register).
REQ-012 run  output  1  pulse generator enable (CTRL[0]).

Function
REQ-013 spi_sck, spi_cs_n and spi_mosi SHALL each pass through a 2-flop synchronizer; edge detection SHALL use the synchronized copies only.
REQ-014 A frame SHALL start on synchronized cs_n fall, which clears the bit counter and shift register.
REQ-015 Frame: bit 0 = W (1 write, 0 read), bits 1-7 = address, bits 8-23 = data; mosi sampled on each synchronized sck rise.
REQ-016 Register map: 0x00 PERIOD (RW), 0x01 WIDTH (RW), 0x02 CTRL (RW; bit0 run, bits 15:1 read 0), 0x03 COUNT (RO), 0x04 STATUS (RO; bit0 run, bit1 pulse_in synchronized).
REQ-017 A write SHALL commit on synchronized cs_n rise only if exactly 24 sck rises occurred in the frame; any other count discards the frame with no register change.
REQ-018 Committed values SHALL appear on outputs on the clk edge after synchronized cs_n rise is detected (≤ 4 clk after the cs_n pin rises).
REQ-019 Writes to read-only or unmapped addresses SHALL be ignored; reads of unmapped addresses SHALL return 16'h0000.
REQ-020 Read: the addressed register SHALL be snapshotted after bit 7 is sampled; data bits SHALL be driven on miso, MSB first, updated on each synchronized sck fall from bit 8 onward.
REQ-021 spi_miso SHALL be 0 when cs_n is high and during bits 0-7, and for all bits of a write frame.
REQ-022 PERIOD/WIDTH writes while run=1 SHALL be accepted into the registers; they take effect in the generator only at its next run low phase.
REQ-023 Writing CTRL with bit0=0 SHALL deassert run on the commit edge regardless of frame address order; a single frame SHALL change only one register.
REQ-024 sck edges while cs_n is high SHALL be ignored.
REQ-025 A cs_n fall occurring before the previous commit completes SHALL NOT corrupt the commit; the commit SHALL take priority in that cycle.

Reset
REQ-026 On rst_n low: PERIOD=PERIOD_RST, WIDTH=WIDTH_RST, CTRL=0 (run=0), COUNT=0, spi_miso=0, bit counter=0, shift register=0, synchronizers to idle (cs_n=1, sck=0).
REQ-027 Reset asserted mid-frame SHALL abort the frame; no write commits after release until a new cs_n fall.

Configuration
REQ-028 Macro PPT_SPI_PULSE_COUNT_EN: when defined, COUNT SHALL increment (wrapping 16'hFFFF to 0) on each synchronized rising edge of pulse_in while run=1, and SHALL clear on any committed CTRL write.
REQ-029 Without PPT_SPI_PULSE_COUNT_EN: no count logic; address 0x03 SHALL read 16'h0000.

Verification
REQ-030 Reset then read 0x00, 0x01, 0x02 -> miso returns 16'h0080, 16'h0001, 16'h0000; run=0.
REQ-031 Write 0x00=16'h03E8, 0x01=16'h0010, 0x02=16'h0001 -> pulse_period=1000, pulse_width=16, run=1 within 4 clk of each cs_n rise.
REQ-032 Write frame to 0x01 with cs_n raised after 20 bits -> WIDTH unchanged; following 24-bit read of 0x01 returns prior value.
REQ-033 With macro defined, run=1, apply 5 pulse_in pulses, read 0x03 -> 16'h0005; write CTRL=1 -> re-read returns 16'h0000.
REQ-034 Assert rst_n low at bit 12 of a write to 0x00=16'h1234 -> PERIOD=16'h0080 after release, no late commit.
REQ-035 Write 0x05=16'hFFFF then read 0x05 and 0x04 -> 16'h0000 from 0x05; 0x04 reflects run and pulse_in; other registers unchanged.
